// File: rtl/ic_cpu_bus_router.sv
// rtl/ic_cpu_bus_router.sv - single-initiator address router to two ic bridges with in-order responses
//
// Decodes each CPU request against two base/mask windows and forwards it to
// target 0, target 1, or answers it locally with an error when unmapped.
// A small route FIFO remembers where each accepted request went so responses
// are returned to the CPU strictly in request order.
//
// Ports:
//   g_clk, g_resetn                 clock, synchronous active-low reset
//   cpu_req/gnt/wen/strb/wdata/addr CPU request channel
//   cpu_recv/ack/error/rdata        CPU response channel
//   tN_req/gnt/wen/strb/wdata/addr  target N request channel (N = 0, 1)
//   tN_recv/ack/error/rdata         target N response channel
module ic_cpu_bus_router #(
    parameter logic [31:0] T0_BASE = 32'h0000_0000,
    parameter logic [31:0] T0_MASK = 32'hFFFF_0000,
    parameter logic [31:0] T1_BASE = 32'h0001_0000,
    parameter logic [31:0] T1_MASK = 32'hFFFF_0000,
    parameter int          DEPTH   = 2
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        cpu_req,
    output logic        cpu_gnt,
    input  logic        cpu_wen,
    input  logic [3:0]  cpu_strb,
    input  logic [31:0] cpu_wdata,
    input  logic [31:0] cpu_addr,
    output logic        cpu_recv,
    input  logic        cpu_ack,
    output logic        cpu_error,
    output logic [31:0] cpu_rdata,
    output logic        t0_req,
    input  logic        t0_gnt,
    output logic        t0_wen,
    output logic [3:0]  t0_strb,
    output logic [31:0] t0_wdata,
    output logic [31:0] t0_addr,
    input  logic        t0_recv,
    output logic        t0_ack,
    input  logic        t0_error,
    input  logic [31:0] t0_rdata,
    output logic        t1_req,
    input  logic        t1_gnt,
    output logic        t1_wen,
    output logic [3:0]  t1_strb,
    output logic [31:0] t1_wdata,
    output logic [31:0] t1_addr,
    input  logic        t1_recv,
    output logic        t1_ack,
    input  logic        t1_error,
    input  logic [31:0] t1_rdata
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        ROUTE_T0  = 2'd0,
        ROUTE_T1  = 2'd1,
        ROUTE_ERR = 2'd2
    } route_t;

    route_t        route_fifo [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    route_t route;
    route_t head;
    logic   full;
    logic   empty;
    logic   push;
    logic   pop;

    // Target 0 wins when both windows match.
    always_comb begin
        if ((cpu_addr & T0_MASK) == T0_BASE) begin
            route = ROUTE_T0;
        end else if ((cpu_addr & T1_MASK) == T1_BASE) begin
            route = ROUTE_T1;
        end else begin
            route = ROUTE_ERR;
        end
    end

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign head  = route_fifo[rd_ptr];

    // Grant depends only on occupancy and target grant, never on cpu_ack,
    // so a full FIFO stays closed even in a cycle that pops.
    always_comb begin
        cpu_gnt = 1'b0;
        if (!full) begin
            case (route)
                ROUTE_T0: cpu_gnt = t0_gnt;
                ROUTE_T1: cpu_gnt = t1_gnt;
                default:  cpu_gnt = 1'b1;
            endcase
        end
    end

    assign t0_req   = cpu_req && (route == ROUTE_T0) && !full;
    assign t1_req   = cpu_req && (route == ROUTE_T1) && !full;
    assign t0_wen   = cpu_wen;
    assign t0_strb  = cpu_strb;
    assign t0_wdata = cpu_wdata;
    assign t0_addr  = cpu_addr;
    assign t1_wen   = cpu_wen;
    assign t1_strb  = cpu_strb;
    assign t1_wdata = cpu_wdata;
    assign t1_addr  = cpu_addr;

    // Only the head target sees cpu_ack; the other one must hold its
    // response, which is what keeps return order equal to request order.
    always_comb begin
        cpu_recv  = 1'b0;
        cpu_error = 1'b0;
        cpu_rdata = 32'h0;
        t0_ack    = 1'b0;
        t1_ack    = 1'b0;
        if (!empty) begin
            case (head)
                ROUTE_T0: begin
                    cpu_recv  = t0_recv;
                    cpu_error = t0_error;
                    cpu_rdata = t0_rdata;
                    t0_ack    = cpu_ack;
                end
                ROUTE_T1: begin
                    cpu_recv  = t1_recv;
                    cpu_error = t1_error;
                    cpu_rdata = t1_rdata;
                    t1_ack    = cpu_ack;
                end
                default: begin
                    cpu_recv  = 1'b1;
                    cpu_error = 1'b1;
                end
            endcase
        end
    end

    assign push = cpu_req && cpu_gnt;
    assign pop  = !empty && cpu_recv && cpu_ack;

    // Entry storage needs no reset: an entry is only read once count covers it.
    always_ff @(posedge g_clk) begin
        if (push) begin
            route_fifo[wr_ptr] <= route;
        end
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
